// File: rtl/route_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// route_pkg
// Constants shared by the path planner and the route command sequencer:
// motion command codes, sequencer state encodings and the default plan depth.
// The planner must encode its direction nibbles with these same codes.
// -----------------------------------------------------------------------------
package route_pkg;

   // Default number of 4-bit command slots in a plan word
   localparam int NCMD_DEF = 16;

   // Motion command codes (one nibble per slot in the plan word)
   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_FWD   = 3'd1;
   localparam logic [2:0] CMD_RIGHT = 3'd2;
   localparam logic [2:0] CMD_UTURN = 3'd3;
   localparam logic [2:0] CMD_LEFT  = 3'd4;

   // Sequencer state encodings
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE      = 3'd0;
   localparam state_t ST_FETCH     = 3'd1;
   localparam state_t ST_ISSUE     = 3'd2;
   localparam state_t ST_WAIT_DONE = 3'd3;
   localparam state_t ST_FINISH    = 3'd4;
   localparam state_t ST_ERROR     = 3'd5;

   // True when a plan nibble is one of the four legal motion codes
   function automatic logic is_valid_cmd(input logic [3:0] nib);
      return (nib >= 4'd1) && (nib <= 4'd4);
   endfunction

endpackage

// File: rtl/route_cmd_sequencer_timeout.sv
// -----------------------------------------------------------------------------
// cmd_timeout_ctr
// Watchdog counter for one motion command. Cleared while the sequencer fetches
// a command, counts every enabled cycle afterwards and flags the cycle that
// is the TIMEOUT-th enabled cycle, so the owner can leave on the next edge.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear (highest priority)
//   i_en           : count enable
//   i_load         : synchronous load of i_load_val
//   i_load_val     : value loaded when i_load is high
//   o_tc           : terminal count reached in this enabled cycle
// -----------------------------------------------------------------------------
module cmd_timeout_ctr #(
   parameter int TIMEOUT = 50_000_000,
   parameter int TO_W    = 26
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clr,
   input  logic            i_en,
   input  logic            i_load,
   input  logic [TO_W-1:0] i_load_val,
   output logic            o_tc
);

   localparam logic [TO_W-1:0] TC_VAL = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] r_count;

   // Cycle counter; holds at the terminal value instead of wrapping
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= {TO_W{1'b0}};
      end else if (i_clr) begin
         r_count <= {TO_W{1'b0}};
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != TC_VAL)) begin
         r_count <= r_count + {{(TO_W-1){1'b0}}, 1'b1};
      end
   end

   // Terminal count: this enabled cycle is the TIMEOUT-th one since the clear
   always_comb begin
      o_tc = 1'b0;
      if (i_en && (r_count == TC_VAL)) begin
         o_tc = 1'b1;
      end else begin
         o_tc = 1'b0;
      end
   end

endmodule

// File: rtl/route_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// route_cmd_sequencer
// Watches the planner's direction word, captures each new non-zero plan and
// replays it one motion command at a time: FETCH a slot, ISSUE it with a
// valid/ready handshake, then WAIT_DONE for the controller's completion pulse.
// Ends in FINISH on a zero nibble or after the last slot, or in ERROR on an
// illegal nibble or a stalled command.
// Ports:
//   clk_50, rst_n        : clock, asynchronous active-low reset
//   plan_in              : planner word, slot 0 in the top nibble
//   abort                : synchronous abort back to IDLE
//   cmd_code/cmd_valid   : command offered to the motor controller
//   cmd_ready/cmd_done   : controller acceptance and completion pulse
//   busy/route_done/error: run status
//   cmd_index/fwd_count  : current slot and completed FWD moves
// -----------------------------------------------------------------------------
module route_cmd_sequencer
   import route_pkg::*;
#(
   parameter int NCMD    = NCMD_DEF,
   parameter int TIMEOUT = 50_000_000,
   parameter int TO_W    = 26
) (
   input  logic              clk_50,
   input  logic              rst_n,
   input  logic [4*NCMD-1:0] plan_in,
   input  logic              abort,
   output logic [2:0]        cmd_code,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   input  logic              cmd_done,
   output logic              busy,
   output logic              route_done,
   output logic              error,
   output logic [4:0]        cmd_index,
   output logic [4:0]        fwd_count
);

   localparam int          PW       = 4 * NCMD;
   localparam logic [4:0]  LAST_IDX = 5'(NCMD);

   state_t          r_state;
   logic [PW-1:0]   r_plan;
   logic [PW-1:0]   r_last;
   logic [2:0]      r_cmd_code;
   logic            r_cmd_valid;
   logic            r_busy;
   logic            r_route_done;
   logic            r_error;
   logic [4:0]      r_cmd_index;
   logic [4:0]      r_fwd_count;

   logic [PW-1:0]   w_shift;
   logic [3:0]      w_nib;
   logic            w_capture;
   logic            w_end;
   logic            w_to_en;
   logic            w_to_clr;
   logic            w_tc;

   // Slot select: shift the current slot into the top nibble; an index of
   // NCMD is caught by w_end before the (all-zero) nibble would matter
   always_comb begin
      w_shift = r_plan << {r_cmd_index, 2'b00};
      w_nib   = w_shift[PW-1 -: 4];
      w_end   = (r_cmd_index == LAST_IDX);
   end

   // A plan is captured only from a resting state and only when it differs
   // from the last one taken, so a static planner word runs exactly once
   always_comb begin
      w_capture = 1'b0;
      if ((r_state == ST_IDLE) || (r_state == ST_FINISH) || (r_state == ST_ERROR)) begin
         w_capture = (plan_in != {PW{1'b0}}) && (plan_in != r_last);
      end else begin
         w_capture = 1'b0;
      end
   end

   // Watchdog runs across both ISSUE and WAIT_DONE of one command
   always_comb begin
      w_to_en  = (r_state == ST_ISSUE) || (r_state == ST_WAIT_DONE);
      w_to_clr = (r_state == ST_FETCH);
   end

   cmd_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .i_clk      (clk_50),
      .i_rst_n    (rst_n),
      .i_clr      (w_to_clr),
      .i_en       (w_to_en),
      .i_load     (1'b0),
      .i_load_val ({TO_W{1'b0}}),
      .o_tc       (w_tc)
   );

   // Sequencer FSM with registered outputs; abort overrides every transition
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_plan       <= {PW{1'b0}};
         r_last       <= {PW{1'b0}};
         r_cmd_code   <= CMD_NONE;
         r_cmd_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_route_done <= 1'b0;
         r_error      <= 1'b0;
         r_cmd_index  <= 5'd0;
         r_fwd_count  <= 5'd0;
      end else if (abort) begin
         // route_done/error and r_last survive so the aborted plan is not rerun
         r_state     <= ST_IDLE;
         r_cmd_code  <= CMD_NONE;
         r_cmd_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_FINISH, ST_ERROR: begin
               if (w_capture) begin
                  r_plan       <= plan_in;
                  r_last       <= plan_in;
                  r_cmd_index  <= 5'd0;
                  r_fwd_count  <= 5'd0;
                  r_route_done <= 1'b0;
                  r_error      <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (w_end || (w_nib == 4'd0)) begin
                  r_state      <= ST_FINISH;
                  r_busy       <= 1'b0;
                  r_route_done <= 1'b1;
                  r_cmd_code   <= CMD_NONE;
               end else if (is_valid_cmd(w_nib)) begin
                  r_state     <= ST_ISSUE;
                  r_cmd_code  <= w_nib[2:0];
                  r_cmd_valid <= 1'b1;
               end else begin
                  r_state    <= ST_ERROR;
                  r_busy     <= 1'b0;
                  r_error    <= 1'b1;
                  r_cmd_code <= CMD_NONE;
               end
            end
            ST_ISSUE: begin
               // Acceptance wins over a coincident terminal count
               if (r_cmd_valid && cmd_ready) begin
                  r_state     <= ST_WAIT_DONE;
                  r_cmd_valid <= 1'b0;
               end else if (w_tc) begin
                  r_state     <= ST_ERROR;
                  r_cmd_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_error     <= 1'b1;
                  r_cmd_code  <= CMD_NONE;
               end
            end
            ST_WAIT_DONE: begin
               // Completion wins over a coincident terminal count
               if (cmd_done) begin
                  r_state     <= ST_FETCH;
                  r_cmd_index <= r_cmd_index + 5'd1;
                  if (r_cmd_code == CMD_FWD) begin
                     r_fwd_count <= r_fwd_count + 5'd1;
                  end
               end else if (w_tc) begin
                  r_state    <= ST_ERROR;
                  r_busy     <= 1'b0;
                  r_error    <= 1'b1;
                  r_cmd_code <= CMD_NONE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_code  <= CMD_NONE;
               r_cmd_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_code   = r_cmd_code;
   assign cmd_valid  = r_cmd_valid;
   assign busy       = r_busy;
   assign route_done = r_route_done;
   assign error      = r_error;
   assign cmd_index  = r_cmd_index;
   assign fwd_count  = r_fwd_count;

endmodule

// File: tb/tb_route_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_route_cmd_sequencer
// Two instances share all inputs: u_a (long watchdog) is checked for the
// functional cases, u_b (TIMEOUT=20) is checked only for the stall case.
// -----------------------------------------------------------------------------
module tb_route_cmd_sequencer;

   logic        clk_50;
   logic        rst_n;
   logic [63:0] plan_in;
   logic        abort;
   logic        cmd_ready;
   logic        cmd_done;

   logic [2:0]  a_cmd_code, b_cmd_code;
   logic        a_cmd_valid, b_cmd_valid;
   logic        a_busy, b_busy;
   logic        a_route_done, b_route_done;
   logic        a_error, b_error;
   logic [4:0]  a_cmd_index, b_cmd_index;
   logic [4:0]  a_fwd_count, b_fwd_count;

   int n_tests = 0;
   int n_fail  = 0;

   route_cmd_sequencer #(.NCMD(16), .TIMEOUT(1000), .TO_W(10)) u_a (
      .clk_50(clk_50), .rst_n(rst_n), .plan_in(plan_in), .abort(abort),
      .cmd_code(a_cmd_code), .cmd_valid(a_cmd_valid), .cmd_ready(cmd_ready),
      .cmd_done(cmd_done), .busy(a_busy), .route_done(a_route_done),
      .error(a_error), .cmd_index(a_cmd_index), .fwd_count(a_fwd_count));

   route_cmd_sequencer #(.NCMD(16), .TIMEOUT(20), .TO_W(5)) u_b (
      .clk_50(clk_50), .rst_n(rst_n), .plan_in(plan_in), .abort(abort),
      .cmd_code(b_cmd_code), .cmd_valid(b_cmd_valid), .cmd_ready(cmd_ready),
      .cmd_done(cmd_done), .busy(b_busy), .route_done(b_route_done),
      .error(b_error), .cmd_index(b_cmd_index), .fwd_count(b_fwd_count));

   initial clk_50 = 1'b0;
   always #10 clk_50 = ~clk_50;

   typedef struct {
      logic [63:0] plan;
      logic [63:0] exp_codes;   // expected issued codes, one per nibble, MSB first
      int          n_issue;
      int          exp_fwd;
      int          exp_idx;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   // Act as the motor controller until u_a leaves busy; ready is always high
   // and done pulses `delay` cycles after acceptance
   task automatic serve(input string name, input int delay, input logic [63:0] exp_codes,
                        output int issues);
      logic [63:0] e;
      logic [3:0]  nib;
      bit          ended;
      e      = exp_codes;
      issues = 0;
      ended  = 1'b0;
      cmd_ready = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if (!a_busy) begin
            ended = 1'b1;
            break;
         end
         if (a_cmd_valid) begin
            if (issues < 16) begin
               nib = e[63 - 4*issues -: 4];
               chk({name, "_code"}, {61'd0, a_cmd_code}, {60'd0, nib});
            end
            issues++;
            tick();
            repeat (delay) tick();
            cmd_done = 1'b1;
            tick();
            cmd_done = 1'b0;
         end else begin
            tick();
         end
      end
      if (!ended) chk({name, "_serve_bound"}, 64'd1, 64'd0);
   endtask

   int   issues;
   int   j;
   bit   stable;

   initial begin
      vecs[0] = '{64'h1411_0000_0000_0000, 64'h1411_0000_0000_0000, 4,  3,  4, 1'b1, 1'b0};
      vecs[1] = '{64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 16, 16, 16, 1'b1, 1'b0};
      vecs[2] = '{64'h1700_0000_0000_0000, 64'h1000_0000_0000_0000, 1,  1,  1, 1'b0, 1'b1};
      vecs[3] = '{64'h2340_0000_0000_0000, 64'h2340_0000_0000_0000, 3,  0,  3, 1'b1, 1'b0};
      vecs[4] = '{64'h0100_0000_0000_0000, 64'h0000_0000_0000_0000, 0,  0,  0, 1'b1, 1'b0};
      vecs[5] = '{64'h4213_1F00_0000_0000, 64'h4213_1000_0000_0000, 5,  2,  5, 1'b0, 1'b1};

      rst_n = 1'b0; plan_in = 64'd0; abort = 1'b0; cmd_ready = 1'b0; cmd_done = 1'b0;
      #25;
      chk("reset_outputs",
          {49'd0, a_cmd_code, a_cmd_valid, a_busy, a_route_done, a_error, a_cmd_index, a_fwd_count},
          64'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_zero_plan_busy", {63'd0, a_busy}, 64'd0);

      // Table-driven plans, done 5 cycles after acceptance
      for (int v = 0; v < 6; v++) begin
         plan_in = vecs[v].plan;
         tick();
         serve($sformatf("vec%0d", v), 4, vecs[v].exp_codes, issues);
         chk($sformatf("vec%0d_issues", v), 64'(issues), 64'(vecs[v].n_issue));
         chk($sformatf("vec%0d_fwd", v), {59'd0, a_fwd_count}, 64'(vecs[v].exp_fwd));
         chk($sformatf("vec%0d_idx", v), {59'd0, a_cmd_index}, 64'(vecs[v].exp_idx));
         chk($sformatf("vec%0d_done", v), {63'd0, a_route_done}, {63'd0, vecs[v].exp_done});
         chk($sformatf("vec%0d_err", v), {63'd0, a_error}, {63'd0, vecs[v].exp_err});
         chk($sformatf("vec%0d_idle", v), {60'd0, a_busy, a_cmd_code}, 64'd0);
      end

      // Backpressure: ready low 100 cycles, early done in the acceptance cycle
      plan_in = 64'h2100_0000_0000_0000;
      cmd_ready = 1'b0;
      tick();
      tick();
      stable = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (!a_cmd_valid || a_cmd_code != 3'd2) stable = 1'b0;
         tick();
      end
      chk("bp_stable", {63'd0, stable}, 64'd1);
      cmd_ready = 1'b1; cmd_done = 1'b1;
      tick();
      cmd_ready = 1'b0; cmd_done = 1'b0;
      chk("bp_valid_drop", {63'd0, a_cmd_valid}, 64'd0);
      repeat (3) tick();
      chk("bp_early_done_ignored", {59'd0, a_cmd_index}, 64'd0);
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      chk("bp_late_done", {59'd0, a_cmd_index}, 64'd1);
      serve("bp_rest", 0, 64'h1000_0000_0000_0000, issues);
      chk("bp_fwd", {59'd0, a_fwd_count}, 64'd1);
      chk("bp_finish", {58'd0, a_route_done, a_cmd_index}, {58'd0, 1'b1, 5'd2});

      // Timeout on u_b: done withheld, error 20 cycles after ISSUE entry
      plan_in = 64'h3000_0000_0000_0000;
      cmd_ready = 1'b1; cmd_done = 1'b0;
      tick();
      tick();
      chk("to_issue_entry", {63'd0, b_cmd_valid}, 64'd1);
      j = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (b_error) begin
            j = k;
            break;
         end
      end
      chk("to_latency", 64'(j), 64'd20);
      chk("to_outputs", {59'd0, b_busy, b_cmd_valid, b_cmd_code}, 64'd0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("to_abort_a", {63'd0, a_busy}, 64'd0);

      // Plan change while busy is deferred; identical plan is not rerun
      plan_in = 64'h1100_0000_0000_0000;
      tick();
      plan_in = 64'h4400_0000_0000_0000;
      serve("chg1", 2, 64'h1100_0000_0000_0000, issues);
      chk("chg1_fwd", {59'd0, a_fwd_count}, 64'd2);
      chk("chg1_done", {63'd0, a_route_done}, 64'd1);
      tick();
      chk("chg2_captured", {62'd0, a_busy, a_route_done}, 64'd2);
      serve("chg2", 0, 64'h4400_0000_0000_0000, issues);
      chk("chg2_state", {54'd0, a_route_done, a_fwd_count, a_cmd_index}, {54'd0, 1'b1, 5'd0, 5'd2});
      repeat (5) tick();
      plan_in = 64'd0;
      tick();
      plan_in = 64'h4400_0000_0000_0000;
      repeat (3) tick();
      chk("same_plan_not_rerun", {62'd0, a_busy, a_route_done}, 64'd1);

      // Abort in WAIT_DONE
      plan_in = 64'h1200_0000_0000_0000;
      cmd_ready = 1'b1;
      tick();
      tick();
      tick();
      chk("ab_wait_state", {59'd0, a_busy, a_cmd_valid, a_cmd_code}, {59'd0, 1'b1, 1'b0, 3'd1});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ab_idle", {52'd0, a_busy, a_cmd_valid, a_cmd_code, a_route_done, a_error, a_cmd_index},
          64'd0);
      repeat (3) tick();
      chk("ab_no_rerun", {63'd0, a_busy}, 64'd0);

      // Asynchronous reset mid-ISSUE, then the same plan is captured again
      plan_in = 64'h2200_0000_0000_0000;
      cmd_ready = 1'b0;
      tick();
      tick();
      chk("rst_pre_issue", {60'd0, a_cmd_valid, a_cmd_code}, {60'd0, 1'b1, 3'd2});
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_outputs",
          {49'd0, a_cmd_code, a_cmd_valid, a_busy, a_route_done, a_error, a_cmd_index, a_fwd_count},
          64'd0);
      @(posedge clk_50);
      #5;
      rst_n = 1'b1;
      tick();
      chk("rst_recapture", {63'd0, a_busy}, 64'd1);
      tick();
      chk("rst_reissue", {60'd0, a_cmd_valid, a_cmd_code}, {60'd0, 1'b1, 3'd2});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
